// File: rtl/mux21_input_conditioner.sv
// mux21_input_conditioner
// Synchronizes and debounces the raw select/data pins for the 2:1 mux stage,
// and optionally replaces the select pin with a free-running toggle whose
// period is programmable (auto mode).
module mux21_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_raw,
  input  logic                in1_raw,
  input  logic                in2_raw,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                sel,
  output logic                in1,
  output logic                in2,
  output logic                sel_toggle,
  output logic                auto_mode
);

  // A counter of at least one bit keeps DEBOUNCE_CYCLES == 1 legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  // Channel index: 0 = select, 1 = data 1, 2 = data 2.
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       db;
  logic [CNT_W-1:0] cnt [3];

  state_t               state;
  state_t               state_nxt;
  logic                 sel_nxt;
  logic [PERIOD_W-1:0]  pcnt;
  logic [PERIOD_W-1:0]  pcnt_nxt;

  assign raw = {in2_raw, in1_raw, sel_raw};

  // Two-flop synchronizers bringing the asynchronous pins into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debouncers: db only follows s2 after DEBOUNCE_CYCLES consecutive mismatches;
  // any cycle of agreement restarts the count, so short glitches vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign in1 = db[1];
  assign in2 = db[2];

  // Next-state and select/period-counter decode. Actions follow the current
  // state, so entering AUTO starts counting from zero on the following edge;
  // a falling auto_en in AUTO suppresses any toggle and just clears the count.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    pcnt_nxt  = pcnt;
    case (state)
      MANUAL: begin
        sel_nxt  = db[0];
        pcnt_nxt = '0;
        if (auto_en) state_nxt = AUTO;
      end
      AUTO: begin
        if (!auto_en) begin
          state_nxt = MANUAL;
          pcnt_nxt  = '0;
        end else if (period == '0) begin
          pcnt_nxt = '0;
        end else if (pcnt >= period - PERIOD_W'(1)) begin
          sel_nxt  = ~sel;
          pcnt_nxt = '0;
        end else begin
          pcnt_nxt = pcnt + PERIOD_W'(1);
        end
      end
      default: begin
        state_nxt = MANUAL;
        pcnt_nxt  = '0;
      end
    endcase
  end

  // State, select and period-counter registers; sel_toggle and auto_mode are
  // registered from the same next-cycle values so they line up with sel/state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MANUAL;
      sel        <= 1'b0;
      pcnt       <= '0;
      sel_toggle <= 1'b0;
      auto_mode  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      pcnt       <= pcnt_nxt;
      sel_toggle <= (sel_nxt != sel);
      auto_mode  <= (state_nxt == AUTO);
    end
  end

endmodule

// File: tb/tb_mux21_input_conditioner.sv
// Directed bench for mux21_input_conditioner (defaults: DEBOUNCE_CYCLES=4, PERIOD_W=8).
module tb_mux21_input_conditioner;

  logic       clk;
  logic       rst;
  logic       sel_raw;
  logic       in1_raw;
  logic       in2_raw;
  logic       auto_en;
  logic [7:0] period;
  logic       sel;
  logic       in1;
  logic       in2;
  logic       sel_toggle;
  logic       auto_mode;

  int checks;
  int failures;
  logic exp_sel;

  mux21_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PERIOD_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel_raw(sel_raw),
    .in1_raw(in1_raw),
    .in2_raw(in2_raw),
    .auto_en(auto_en),
    .period(period),
    .sel(sel),
    .in1(in1),
    .in2(in2),
    .sel_toggle(sel_toggle),
    .auto_mode(auto_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sel_raw  = 1'b1;
    in1_raw  = 1'b1;
    in2_raw  = 1'b1;
    auto_en  = 1'b0;
    period   = 8'd0;

    // Reset held 3 cycles with all raw inputs high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outs", {27'd0, sel, in1, in2, sel_toggle, auto_mode}, 32'd0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("rel_in1", in1, (e >= 6));
      chk("rel_in2", in2, (e >= 6));
      chk("rel_sel", sel, (e >= 7));
      chk("rel_tog", sel_toggle, (e == 7));
      chk("rel_auto", auto_mode, 0);
    end

    // Glitch rejection on in2: first bring in2 low
    in2_raw = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    chk("in2_low", in2, 0);
    in2_raw = 1'b1;
    for (int e = 1; e <= 3; e++) step();
    in2_raw = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("glitch_in2", in2, 0);
    end
    in2_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("held_in2", in2, (e >= 6));
    end

    // Auto mode, period 3, sel_raw random
    period  = 8'd3;
    auto_en = 1'b1;
    exp_sel = 1'b1;
    step();
    chk("auto_enter_mode", auto_mode, 1);
    chk("auto_enter_sel", sel, exp_sel);
    chk("auto_enter_tog", sel_toggle, 0);
    for (int k = 1; k <= 12; k++) begin
      sel_raw = 1'($urandom_range(0, 1));
      step();
      if (k % 3 == 0) exp_sel = ~exp_sel;
      chk("auto3_sel", sel, exp_sel);
      chk("auto3_tog", sel_toggle, (k % 3 == 0));
      chk("auto3_mode", auto_mode, 1);
    end

    // Auto mode, period 0: sel frozen
    sel_raw = 1'b0;
    period  = 8'd0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("auto0_sel", sel, exp_sel);
      chk("auto0_tog", sel_toggle, 0);
    end

    // Period 8, count to pcnt=5, then lower period to 2
    period = 8'd8;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("p8_tog", sel_toggle, 0);
    end
    period = 8'd2;
    for (int i = 0; i <= 7; i++) begin
      step();
      if (i % 2 == 0) exp_sel = ~exp_sel;
      chk("p2_sel", sel, exp_sel);
      chk("p2_tog", sel_toggle, (i % 2 == 0));
    end

    // auto_en drops on an edge that would have toggled: sel holds
    auto_en = 1'b0;
    step();
    chk("exit_sel_hold", sel, 1);
    chk("exit_tog", sel_toggle, 0);
    chk("exit_mode", auto_mode, 0);
    step();
    chk("manual_sel", sel, 0);
    chk("manual_tog", sel_toggle, 1);
    step();
    chk("manual_tog_clr", sel_toggle, 0);

    // Reset mid-debounce (in1 counter at 2)
    in1_raw = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    chk("pre_rst_in1", in1, 1);
    rst = 1'b1;
    step();
    chk("midrst_outs", {27'd0, sel, in1, in2, sel_toggle, auto_mode}, 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("post_in1", in1, 0);
      chk("post_in2", in2, (e >= 6));
      chk("post_sel", sel, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux21_input_conditioner.md
# mux21_input_conditioner

Upstream conditioning stage for the 2:1 mux datapath. Takes the three raw pad-level inputs (select, data 1, data 2), synchronizes and debounces each, and produces clean registered `sel`, `in1`, `in2` for the mux stage. It also has an auto-select mode that toggles `sel` at a programmable period, so the mux can be exercised without touching the select pin.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced output changes. Legal range is at least 1.
- `PERIOD_W`, default 8: width of the `period` input.

Ports:
- `clk`  input  1: sole clock; all logic on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `sel_raw`  input  1: raw select pin; asynchronous.
- `in1_raw`  input  1: raw data input 1; asynchronous.
- `in2_raw`  input  1: raw data input 2; asynchronous.
- `auto_en`  input  1: auto-select mode enable; synchronous to `clk`, not debounced.
- `period`  input  PERIOD_W: auto-mode toggle period in cycles; synchronous.
- `sel`  output  1: conditioned select to the mux.
- `in1`  output  1: conditioned data 1 to the mux.
- `in2`  output  1: conditioned data 2 to the mux.
- `sel_toggle`  output  1: single-cycle pulse, high in the same cycle `sel` takes a new value.
- `auto_mode`  output  1: high while the FSM is in AUTO.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer (`s1`, `s2`). Both flops reset to 0.
- **Debouncer, one per channel:** holds a stable value `db` and a counter `cnt`. The counter is sized for `DEBOUNCE_CYCLES-1`.
  - If `s2 == db` on an edge, `cnt` is set to 0.
  - If `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`, then `db` is set to `s2` and `cnt` is set to 0.
  - If `s2 != db` otherwise, `cnt` increments.
  - A mismatch shorter than `DEBOUNCE_CYCLES` cycles is rejected completely.
- **Data outputs:** `in1` and `in2` are the `db` registers of their channels, driven directly.
- **FSM with two states, MANUAL and AUTO** (reset state MANUAL):
  - MANUAL goes to AUTO when `auto_en` = 1. AUTO goes to MANUAL when `auto_en` = 0. Each transition takes one edge.
  - In MANUAL, the `sel` register loads the debounced select value every edge. The period counter `pcnt` (PERIOD_W bits) is held at 0.
  - In AUTO, the debounced select value is ignored.
    - If `period` == 0, `sel` holds and `pcnt` stays at 0.
    - Otherwise, if `pcnt >= period-1`, `sel` inverts and `pcnt` is set to 0.
    - Otherwise, `pcnt` increments.
  - The `>=` comparison means lowering `period` mid-count causes a toggle on the next edge, never a wrap through 2^PERIOD_W.
  - On entering AUTO, `sel` keeps its current value and counting starts from `pcnt` = 0.
  - On returning to MANUAL, `sel` loads the debounced select on the first MANUAL edge. If the two differ, that is a normal toggle with a `sel_toggle` pulse.
- **`sel_toggle`:** registered. It is 1 on exactly the edge where the `sel` register changes value, and 0 otherwise.
- **`auto_mode`:** registered decode of the FSM state.

## Timing
- **Reset values:** `sel`, `in1`, `in2`, `sel_toggle`, `auto_mode` = 0. All synchronizer flops, debounce registers, `cnt` and `pcnt` = 0. The FSM is in MANUAL.
- **Reset behaviour:**
  - Reset takes effect on the first edge with `rst` = 1, including mid-debounce or mid-period.
  - `rst` overrides `auto_en`.
  - The first edge with `rst` = 0 samples the raw inputs normally.
- **Debounce latency:** take the edge that first samples a held raw change as edge 1. `db` updates on edge `DEBOUNCE_CYCLES`+2, which is edge 6 with the default of 4.
- **Select path in MANUAL:** `sel` lags its debounced value by one more edge, so raw `sel_raw` to `sel` takes `DEBOUNCE_CYCLES`+3 edges. Data channels take `DEBOUNCE_CYCLES`+2 edges.
- **Auto period:** with a constant `period` = P > 0, `sel` toggles every P edges. The first toggle comes P edges after the FSM enters AUTO; the FSM enters AUTO one edge after `auto_en` rises.
- **Simultaneous events:**
  - A raw edge landing while `cnt` is mid-count in the opposite direction simply clears or continues the count per the rules above. No special case.
  - `auto_en` falling on the same edge as an auto toggle: the toggle does not occur; the FSM leaves AUTO first.
- **Outputs:** all outputs are registered. There are no combinational input-to-output paths.

## Test plan
1. **Reset:** hold `rst`=1 for 3 cycles with all raw inputs at 1. Required: all outputs are 0 throughout. After release: `in1`=`in2`=1 on edge 6 and `sel`=1 on edge 7, with `sel_toggle`=1 on edge 7 only.
2. **Glitch rejection:** `in2_raw` high for 3 cycles, then low. Required: `in2` stays 0. Then `in2_raw` high and held. Required: `in2`=1 on edge 6.
3. **Auto mode, `period`=3:** `auto_en`=1 with `sel_raw` toggling randomly. Required: `auto_mode`=1 one edge later; `sel` toggles every 3 edges, with a `sel_toggle` pulse on each toggle; `sel_raw` has no effect.
4. **Auto mode, `period`=0:** Required: `sel` is constant and `sel_toggle` stays 0 for 20 cycles.
5. **Period lowered mid-count:** in AUTO with `period`=8 and `pcnt`=5, change `period` to 2. Required: `sel` toggles on the next edge, then every 2 edges.
6. **Exit and reset mid-operation:** leave AUTO with `sel`=1 and debounced select = 0. Required: `sel`=0 with a `sel_toggle` pulse on the first MANUAL edge. Then assert `rst` while `cnt`=2. Required: all outputs are 0 on the next edge.
